// File: rtl/countdown_timer_bcd.sv
// Three-digit BCD countdown timer with 0.1 s resolution (d2 = tens of s, d1 = s, d0 = tenths).
// A preset is loaded, counted down while go is high, and the timer halts at 00.0 with a
// single-cycle done_tick for the alarm/sequencer logic.
module countdown_timer_bcd #(
    parameter int unsigned DVSR = 5000000,
    parameter int unsigned PW   = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       go,
    input  logic [3:0] din2,
    input  logic [3:0] din1,
    input  logic [3:0] din0,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       done_tick
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [PW-1:0] LastCnt = PW'(DVSR - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic          done_q, done_d;
    logic          tick;
    logic          is_zero;
    logic          is_one;

    // Out-of-range BCD preset nibbles saturate to 9.
    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign tick    = (state_q == StRun) && go && (presc_q == LastCnt);
    assign is_zero = ({d2_q, d1_q, d0_q} == 12'h000);
    assign is_one  = ({d2_q, d1_q, d0_q} == 12'h001);

    // Next-state: load overrides everything; otherwise FSM, prescaler and BCD borrow chain.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        done_d  = 1'b0;
        if (load) begin
            d2_d    = clamp9(din2);
            d1_d    = clamp9(din1);
            d0_d    = clamp9(din0);
            presc_d = '0;
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // A zero preset never starts, so 000 is never decremented.
                    if (go && !is_zero) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tick) begin
                        presc_d = '0;
                        if (d0_q != 4'd0) begin
                            d0_d = d0_q - 4'd1;
                        end else begin
                            d0_d = 4'd9;
                            if (d1_q != 4'd0) begin
                                d1_d = d1_q - 4'd1;
                            end else begin
                                d1_d = 4'd9;
                                d2_d = d2_q - 4'd1;
                            end
                        end
                        if (is_one) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end else if (go) begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                StDone: begin
                    presc_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            done_q  <= done_d;
        end
    end

    assign d2        = d2_q;
    assign d1        = d1_q;
    assign d0        = d0_q;
    assign running   = (state_q == StRun);
    assign done_tick = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd: a value-level reference model pushes the expected
// post-edge outputs into a scoreboard queue, which is popped and compared after every edge.
// Directed checks against hand-derived constants cover the key timing points.
module tb_countdown_timer_bcd;

    localparam int unsigned DVSR = 4;
    localparam int unsigned PW   = 3;

    logic       clk = 1'b0;
    logic       reset, load, go;
    logic [3:0] din2, din1, din0;
    logic [3:0] d2, d1, d0;
    logic       running, done_tick;

    countdown_timer_bcd #(.DVSR(DVSR), .PW(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .go        (go),
        .din2      (din2),
        .din1      (din1),
        .din0      (din0),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .running   (running),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the count is held as a plain integer 0..999.
    int m_val  = 0;
    int m_pre  = 0;
    int m_mode = 0;  // 0 idle, 1 run, 2 done
    int m_done = 0;

    logic [13:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat9(input logic [3:0] v);
        return (v > 4'd9) ? 9 : int'(v);
    endfunction

    task automatic model_step(input logic rst, input logic ld, input logic g,
                              input logic [3:0] i2, input logic [3:0] i1, input logic [3:0] i0);
        m_done = 0;
        if (rst) begin
            m_val  = 0;
            m_pre  = 0;
            m_mode = 0;
        end else if (ld) begin
            m_val  = sat9(i2) * 100 + sat9(i1) * 10 + sat9(i0);
            m_pre  = 0;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (g && m_val != 0) m_mode = 1;
        end else if (m_mode == 1 && g) begin
            if (m_pre == int'(DVSR) - 1) begin
                m_pre = 0;
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_mode = 2;
                    m_done = 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [3:0] e2, e1, e0;
        e2 = 4'(m_val / 100);
        e1 = 4'((m_val / 10) % 10);
        e0 = 4'(m_val % 10);
        return {e2, e1, e0, (m_mode == 1), (m_done == 1)};
    endfunction

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic ld, input logic g,
                        input logic [3:0] i2, input logic [3:0] i1, input logic [3:0] i0);
        logic [13:0] e;
        reset = rst;
        load  = ld;
        go    = g;
        din2  = i2;
        din1  = i1;
        din0  = i0;
        model_step(rst, ld, g, i2, i1, i0);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, 16'({d2, d1, d0, running, done_tick}), 16'(e));
    endtask

    task automatic run(input string tag, input int n, input logic g);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, g, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic ld(input string tag, input logic g, input logic [3:0] i2, input logic [3:0] i1,
                      input logic [3:0] i0);
        step(tag, 1'b0, 1'b1, g, i2, i1, i0);
    endtask

    function automatic logic [15:0] digs();
        return 16'({d2, d1, d0});
    endfunction

    int pulses;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        go    = 1'b0;
        din2  = 4'd0;
        din1  = 4'd0;
        din0  = 4'd0;
        step("init_rst", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

        // 1: random activity, then reset
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'b0, ($urandom_range(0, 9) == 0), 1'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom));
        end
        step("t1_rst", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        check("t1_digits", digs(), 16'h000);
        check("t1_running", 16'(running), 16'd0);
        check("t1_done", 16'(done_tick), 16'd0);
        // reset together with load: reset wins
        ld("t1_ld", 1'b0, 4'd4, 4'd4, 4'd4);
        step("t1_rst_ld", 1'b1, 1'b1, 1'b0, 4'd7, 4'd7, 4'd7);
        check("t1_rst_ld_dig", digs(), 16'h000);

        // 2: 100 -> 099 -> 098
        ld("t2_ld", 1'b0, 4'd1, 4'd0, 4'd0);
        run("t2_start", 1, 1'b1);
        check("t2_running", 16'(running), 16'd1);
        run("t2_run", 3, 1'b1);
        check("t2_pre", digs(), 16'h100);
        run("t2_run", 1, 1'b1);
        check("t2_099", digs(), 16'h099);
        run("t2_run", 4, 1'b1);
        check("t2_098", digs(), 16'h098);
        check("t2_running2", 16'(running), 16'd1);

        // 3: 002 -> 001 -> 000, single done_tick, then hold
        ld("t3_ld", 1'b1, 4'd0, 4'd0, 4'd2);
        run("t3_start", 1, 1'b1);
        run("t3_run", 4, 1'b1);
        check("t3_001", digs(), 16'h001);
        run("t3_run", 4, 1'b1);
        check("t3_000", digs(), 16'h000);
        check("t3_done", 16'(done_tick), 16'd1);
        check("t3_stop", 16'(running), 16'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            run("t3_hold", 1, 1'b1);
            if (done_tick) pulses++;
        end
        check("t3_no_more_done", 16'(pulses), 16'd0);
        check("t3_hold_dig", digs(), 16'h000);

        // 4: pause mid-period keeps partial progress
        ld("t4_ld", 1'b0, 4'd0, 4'd0, 4'd5);
        run("t4_start", 1, 1'b1);
        run("t4_run", 2, 1'b1);
        run("t4_pause", 20, 1'b0);
        check("t4_paused", digs(), 16'h005);
        run("t4_resume", 1, 1'b1);
        check("t4_not_yet", digs(), 16'h005);
        run("t4_resume", 1, 1'b1);
        check("t4_004", digs(), 16'h004);

        // 5: load while running, then load coincident with a tick
        ld("t5_ld", 1'b1, 4'd0, 4'd3, 4'd0);
        check("t5_loaded", digs(), 16'h030);
        check("t5_idle", 16'(running), 16'd0);
        run("t5_start", 1, 1'b1);
        check("t5_run", 16'(running), 16'd1);
        run("t5_run", 3, 1'b1);
        check("t5_still", digs(), 16'h030);
        run("t5_run", 1, 1'b1);
        check("t5_029", digs(), 16'h029);
        run("t5_run", 3, 1'b1);
        ld("t5_ld_tick", 1'b1, 4'd0, 4'd5, 4'd5);
        check("t5_ld_tick_dig", digs(), 16'h055);
        check("t5_ld_tick_done", 16'(done_tick), 16'd0);

        // 6: clamp and zero preset
        ld("t6_clamp", 1'b0, 4'hF, 4'hF, 4'd0);
        check("t6_990", digs(), 16'h990);
        ld("t6_zero", 1'b1, 4'd0, 4'd0, 4'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            run("t6_hold", 1, 1'b1);
            if (done_tick || running) pulses++;
        end
        check("t6_stays_idle", 16'(pulses), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
